// File: rtl/cpu_seq.sv
// cpu_seq: instruction sequencer for the 8-bit accumulator CPU.
// Owns PC/IR and steps each instruction through FETCH, DECODE, EXEC_A, EXEC_B.
`default_nettype none

module cpu_seq #(
    parameter int         ADDR_W   = 5,
    parameter logic [4:0] SHR_CODE = 5'h1f
) (
    input  logic              tclk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              c,
    input  logic              z,
    input  logic [7:0]        d_bus,
    output logic [7:0]        ir,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic              ldAcc,
    output logic              useAlu,
    output logic              dbusSelect,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC_A = 2'b10,
        S_EXEC_B = 2'b11
    } state_t;

    localparam logic [2:0] OP_LD = 3'b100;
    localparam logic [2:0] OP_ST = 3'b101;
    localparam logic [2:0] OP_JC = 3'b110;
    localparam logic [2:0] OP_JZ = 3'b111;

    state_t              state_q;
    logic [7:0]          ir_q;
    logic [ADDR_W-1:0]   pc_q;

    logic [2:0]          w_opcode;
    logic [ADDR_W-1:0]   w_operand;
    logic                w_is_arith;
    logic                w_jump_taken;

    assign w_opcode     = ir_q[7:5];
    assign w_operand    = ir_q[ADDR_W-1:0];
    assign w_is_arith   = ~ir_q[7];
    assign w_jump_taken = ((w_opcode == OP_JC) && c) || ((w_opcode == OP_JZ) && z);

    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= 8'h00;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (run || step) begin
                        ir_q    <= d_bus;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc_q    <= pc_q + ADDR_W'(1);
                    state_q <= S_EXEC_A;
                end
                S_EXEC_A: begin
                    // A taken jump overrides the increment made in DECODE
                    if (w_jump_taken) begin
                        pc_q <= w_operand;
                    end
                    state_q <= S_EXEC_B;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        addr       = w_operand;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        ldAcc      = 1'b0;
        useAlu     = 1'b0;
        dbusSelect = 1'b0;
        case (state_q)
            S_FETCH: begin
                addr   = pc_q;
                mem_re = 1'b1;
            end
            S_EXEC_A: begin
                if (w_is_arith) begin
                    mem_re = 1'b1;
                    useAlu = 1'b1;
                end else if (w_opcode == OP_LD) begin
                    mem_re = 1'b1;
                    ldAcc  = 1'b1;
                end else if (w_opcode == OP_ST) begin
                    useAlu = 1'b1;
                end
            end
            S_EXEC_B: begin
                // Write-back phase: only the ALU latch ever drives d_bus here
                if (w_is_arith) begin
                    dbusSelect = 1'b1;
                    ldAcc      = 1'b1;
                end else if (w_opcode == OP_ST) begin
                    dbusSelect = 1'b1;
                    mem_we     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign ir    = ir_q;
    assign pc    = pc_q;
    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed self-checking bench for cpu_seq with a memory and accumulator model.
`default_nettype none

module tb_cpu_seq;

    logic       tclk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       c;
    logic       z;
    logic [7:0] d_bus;
    logic [7:0] ir;
    logic [4:0] pc;
    logic [4:0] addr;
    logic       mem_re;
    logic       mem_we;
    logic       ldAcc;
    logic       useAlu;
    logic       dbusSelect;
    logic [1:0] state;

    logic [7:0] mem [0:31];
    logic [7:0] acc;
    logic [7:0] latch;

    int n_pass  = 0;
    int n_total = 0;

    cpu_seq #(.ADDR_W(5), .SHR_CODE(5'h1f)) dut (
        .tclk       (tclk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .c          (c),
        .z          (z),
        .d_bus      (d_bus),
        .ir         (ir),
        .pc         (pc),
        .addr       (addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .ldAcc      (ldAcc),
        .useAlu     (useAlu),
        .dbusSelect (dbusSelect),
        .state      (state)
    );

    always #5 tclk = ~tclk;

    assign d_bus = mem_re ? mem[addr] : (dbusSelect ? latch : 8'h00);

    always @(posedge tclk) begin
        if (mem_we) mem[addr] = d_bus;
    end

    always @(posedge tclk) begin
        if (ldAcc)  acc   <= d_bus;
        if (useAlu) latch <= mem_re ? (acc + d_bus) : acc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge tclk) begin
        chk("bus_excl_re_sel", {31'd0, mem_re & dbusSelect}, 32'd0);
        chk("bus_excl_we_sel", {31'd0, mem_we & ~dbusSelect}, 32'd0);
    end

    task automatic tick();
        @(posedge tclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0] = 8'h85; mem[1] = 8'h06; mem[2] = 8'hA7; mem[3] = 8'h88;
        mem[4] = 8'hE3; mem[5] = 8'h2A; mem[6] = 8'h01; mem[8] = 8'h00;
        acc = 8'h00; latch = 8'h00;
        reset = 1'b1; run = 1'b0; step = 1'b0; c = 1'b0; z = 1'b0;
        ticks(2);
        chk("rst_state",  {30'd0, state}, 32'd0);
        chk("rst_pc",     {27'd0, pc},    32'd0);
        chk("rst_ir",     {24'd0, ir},    32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd1);
        chk("rst_strobes", {28'd0, mem_we, ldAcc, useAlu, dbusSelect}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_hold_pc", {27'd0, pc}, 32'd0);

        // LD 5
        run = 1'b1;
        chk("ld_f_addr", {27'd0, addr}, 32'd0);
        chk("ld_f_ldacc", {31'd0, ldAcc}, 32'd0);
        tick();
        chk("ld_d_ir", {24'd0, ir}, 32'h85);
        chk("ld_d_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'd0);
        chk("ld_d_addr", {27'd0, addr}, 32'd5);
        tick();
        chk("ld_a_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'b10100);
        chk("ld_a_pc", {27'd0, pc}, 32'd1);
        tick();
        chk("ld_b_state", {30'd0, state}, 32'd3);
        chk("ld_b_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'd0);
        chk("ld_acc", {24'd0, acc}, 32'h2A);
        tick();
        chk("ld_next_state", {30'd0, state}, 32'd0);
        chk("ld_next_pc", {27'd0, pc}, 32'd1);
        chk("ld_next_addr", {27'd0, addr}, 32'd1);

        // ADD 6
        ticks(2);
        chk("add_a_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'b10010);
        tick();
        chk("add_b_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'b00101);
        tick();
        chk("add_acc", {24'd0, acc}, 32'h2B);
        chk("add_pc", {27'd0, pc}, 32'd2);

        // ST 7
        ticks(2);
        chk("st_a_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'b00010);
        tick();
        chk("st_b_strb", {27'd0, mem_re, mem_we, ldAcc, useAlu, dbusSelect}, 32'b01001);
        chk("st_b_addr", {27'd0, addr}, 32'd7);
        tick();
        chk("st_mem7", {24'd0, mem[7]}, 32'h2B);
        chk("st_pc", {27'd0, pc}, 32'd3);

        // LD 8, run dropped during EXEC_A
        ticks(2);
        chk("runoff_in_ea", {30'd0, state}, 32'd2);
        run = 1'b0;
        ticks(2);
        chk("runoff_state", {30'd0, state}, 32'd0);
        chk("runoff_pc", {27'd0, pc}, 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_state", {30'd0, state}, 32'd0);
            chk("stall_pc", {27'd0, pc}, 32'd4);
        end

        // JZ 3 taken, single step
        z = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("jz_ir", {24'd0, ir}, 32'hE3);
        ticks(2);
        chk("jz_t_pc_eb", {27'd0, pc}, 32'd3);
        tick();
        chk("jz_t_state", {30'd0, state}, 32'd0);
        chk("jz_t_addr", {27'd0, addr}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("step_hold_state", {30'd0, state}, 32'd0);
            chk("step_hold_pc", {27'd0, pc}, 32'd3);
        end

        // Step LD 8 back to pc=4, then JZ 3 not taken
        step = 1'b1; tick(); step = 1'b0; ticks(3);
        chk("step_ld_pc", {27'd0, pc}, 32'd4);
        z = 1'b0;
        step = 1'b1; tick(); step = 1'b0; ticks(3);
        chk("jz_nt_pc", {27'd0, pc}, 32'd5);
        chk("jz_nt_addr", {27'd0, addr}, 32'd5);

        // JC 31, then JC 0 at pc=31 wraps to 0
        reset = 1'b1; tick(); reset = 1'b0;
        mem[0] = 8'hDF; mem[31] = 8'hC0; c = 1'b1; run = 1'b1;
        ticks(4);
        chk("jc31_pc", {27'd0, pc}, 32'd31);
        ticks(4);
        chk("jc0_pc", {27'd0, pc}, 32'd0);
        chk("jc0_addr", {27'd0, addr}, 32'd0);

        // Increment wrap 31 -> 0
        ticks(4);
        chk("wrap_pre_pc", {27'd0, pc}, 32'd31);
        mem[31] = 8'h80;
        ticks(4);
        chk("wrap_inc_pc", {27'd0, pc}, 32'd0);

        // Reset during EXEC_B of ST 9
        mem[0] = 8'hA9; mem[9] = 8'h55;
        ticks(3);
        chk("rst_st_we_pre", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_st_we", {31'd0, mem_we}, 32'd0);
        chk("rst_st_state", {30'd0, state}, 32'd0);
        chk("rst_st_pc", {27'd0, pc}, 32'd0);
        chk("rst_st_ir", {24'd0, ir}, 32'd0);
        tick();
        chk("rst_st_mem9", {24'd0, mem[9]}, 32'h55);
        reset = 1'b0;
        run = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Instruction sequencer for the 8-bit accumulator CPU.
- Owns the program counter (PC) and instruction register (IR), and steps each instruction through FETCH, DECODE, EXEC_A and EXEC_B.
- Drives the ALU/accumulator controls (ldAcc, useAlu, dbusSelect) and the memory read/write strobes. Takes the carry and zero flags back from the ALU for conditional jumps.
- Sits between program/data memory, the shared d_bus and the ALU.

Parameters:
ADDR_W, 5, width of PC, memory address and instruction operand field (instruction[ADDR_W-1:0])
SHR_CODE, 5'h1f, operand value that selects right shift for SHIFT (informational; decoded in ALU)

Ports:
tclk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  free-run enable; sequencer may leave FETCH only when run=1 or step=1
step  input  1  single-step request, sampled in FETCH
c  input  1  carry flag from ALU
z  input  1  zero flag from ALU
d_bus  input  8  data bus, read side (memory read data in FETCH)
ir  output  8  instruction register, drives ALU instruction input
pc  output  ADDR_W  program counter
addr  output  ADDR_W  memory address
mem_re  output  1  memory read enable (memory drives d_bus)
mem_we  output  1  memory write enable (writes d_bus to addr)
ldAcc  output  1  load accumulator from d_bus
useAlu  output  1  ALU operation strobe
dbusSelect  output  1  ALU latch drives d_bus
state  output  2  FETCH=00, DECODE=01, EXEC_A=10, EXEC_B=11

Behaviour:
- Reset (async, immediate): state=FETCH, pc=0, ir=8'h00. All strobes low except mem_re=1 (FETCH decode). Reset mid-instruction aborts it; mem_we falls with reset, no partial write.
- Opcode is ir[7:5]; operand is ir[4:0].
  - 000 ADD, 001 SUB, 010 NAND, 011 SHIFT (arith class)
  - 100 LD, 101 ST
  - 110 JC (jump if c=1), 111 JZ (jump if z=1)
- Strobes are combinational from state and ir. Registers update on the rising edge of tclk.
- FETCH:
  - addr=pc, mem_re=1.
  - If run|step: ir<=d_bus, go to DECODE. Otherwise hold; pc and ir are unchanged.
  - step is level-sampled: holding it high is equivalent to run.
- DECODE: addr=ir[4:0], mem_re=0, pc<=pc+1 (wraps 31->0), go to EXEC_A.
- EXEC_A: addr=ir[4:0].
  - Arith: mem_re=1, useAlu=1.
  - LD: mem_re=1, ldAcc=1.
  - ST: useAlu=1, mem_re=0 (ALU copies acc to latch).
  - JC/JZ: no strobes; if the flag is set, pc<=ir[4:0], overriding the DECODE increment.
  - Always go to EXEC_B.
- EXEC_B: addr=ir[4:0].
  - Arith: dbusSelect=1, ldAcc=1 (result written back to acc).
  - ST: dbusSelect=1, mem_we=1.
  - LD/JC/JZ: idle cycle.
  - Always go to FETCH.
- Every instruction takes exactly 4 cycles; there is no early termination.
- Bus exclusivity is an invariant: mem_re and dbusSelect are never both 1, and mem_we is only 1 while dbusSelect=1.
- Flags are sampled in EXEC_A, so the flags seen are those set by the most recent arith instruction's EXEC_A edge.
- run falling mid-instruction: the current instruction completes, then the sequencer stalls in FETCH.
- Jump target equal to the jump's own address is legal (idle loop).
- pc wrap applies to both increment and jump.
- Unused operand bits of LD/ST/JC/JZ are still driven onto addr; the decode ignores nothing else.

Test Plan:
- Reset then run=1, mem[0]=8'h85 (LD 5), mem[5]=8'h2A -> ldAcc high only in the 3rd cycle, acc=8'h2A; pc=1 at the next FETCH; 4 cycles total.
- mem[1]=8'h06 (ADD 6), acc=8'h2A, mem[6]=8'h01 -> EXEC_A: mem_re=1, useAlu=1. EXEC_B: dbusSelect=1, ldAcc=1, mem_re=0. acc=8'h2B.
- mem[2]=8'hA7 (ST 7) -> EXEC_A: useAlu=1, mem_re=0. EXEC_B: mem_we=1, addr=7, dbusSelect=1. mem[7]=acc.
- JZ 3 (8'hE3) at pc=4:
  - z=1 -> next FETCH addr=3.
  - z=0 -> next FETCH addr=5.
  - JC 0 (8'hC0) with c=1 at pc=31 -> pc=0.
  - pc increment from 31 without a jump -> 0.
- run=0, step pulsed one cycle -> exactly one instruction executes, then state holds at FETCH with pc stable for 10 cycles. Deasserting run during EXEC_A finishes that instruction.
- Assert reset during EXEC_B of ST -> mem_we drops the same cycle (before the edge), state=FETCH, pc=0, ir=0. Checker asserts bus exclusivity on every cycle of all tests.
